// File: rtl/bloom_cmd_initiator.sv
// Initiator for the bloom filter start/done interface: takes one command at a time,
// drives the filter pins, and returns a registered response with timeout and saturating stats.
module bloom_cmd_initiator #(
  parameter int KEY_W   = 32,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic             cmd_clear,
  input  logic [KEY_W-1:0] cmd_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_op,
  output logic             rsp_clear,
  output logic [KEY_W-1:0] rsp_key,
  output logic             rsp_hit,
  output logic             rsp_err,
  output logic             bf_start,
  output logic             bf_op_insert,
  output logic             bf_clear_all,
  output logic [KEY_W-1:0] bf_key,
  input  logic             bf_busy,
  input  logic             bf_done,
  input  logic             bf_hit,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_inserts,
  output logic [CNT_W-1:0] stat_queries,
  output logic [CNT_W-1:0] stat_hits,
  output logic [CNT_W-1:0] stat_timeouts
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic             op_r;
  logic [KEY_W-1:0] key_r;
  logic [TMR_W-1:0] timer_r;
  logic             cmd_ready_r;
  logic             clear_all_r;
  logic             rsp_valid_r;
  logic             rsp_op_r;
  logic             rsp_clear_r;
  logic [KEY_W-1:0] rsp_key_r;
  logic             rsp_hit_r;
  logic             rsp_err_r;
  logic [CNT_W-1:0] inserts_r;
  logic [CNT_W-1:0] queries_r;
  logic [CNT_W-1:0] hits_r;
  logic [CNT_W-1:0] timeouts_r;
  logic             accept_s;
  logic             start_s;
  logic             wait_exit_s;
  logic             drive_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept_s    = (state_r == ST_IDLE) && cmd_ready_r && cmd_valid;
  assign start_s     = (state_r == ST_ISSUE) && !bf_busy && !bf_done;
  assign wait_exit_s = (state_r == ST_WAIT) && (bf_done || (timer_r == TMR_LAST));
  assign drive_s     = (state_r == ST_ISSUE) || (state_r == ST_WAIT);

  // Next-state decode for the command FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = accept_s ? (cmd_clear ? ST_CLEAR : ST_ISSUE) : ST_IDLE;
      ST_ISSUE: state_nxt_s = start_s ? ST_WAIT : ST_ISSUE;
      ST_WAIT:  state_nxt_s = wait_exit_s ? ST_RESP : ST_WAIT;
      ST_CLEAR: state_nxt_s = ST_RESP;
      ST_RESP:  state_nxt_s = rsp_ready ? ST_IDLE : ST_RESP;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, command latch, wait timer and the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      op_r        <= 1'b0;
      key_r       <= {KEY_W{1'b0}};
      timer_r     <= {TMR_W{1'b0}};
      cmd_ready_r <= 1'b0;
      clear_all_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_op_r    <= 1'b0;
      rsp_clear_r <= 1'b0;
      rsp_key_r   <= {KEY_W{1'b0}};
      rsp_hit_r   <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cmd_ready_r <= (state_nxt_s == ST_IDLE);
      clear_all_r <= (state_nxt_s == ST_CLEAR);
      if (accept_s) begin
        op_r  <= cmd_op;
        key_r <= cmd_key;
      end
      if (start_s) begin
        timer_r <= {TMR_W{1'b0}};
      end else if (state_r == ST_WAIT) begin
        timer_r <= timer_r + TMR_W'(1);
      end
      // A done on the expiry cycle still wins over the timeout.
      if (wait_exit_s) begin
        rsp_valid_r <= 1'b1;
        rsp_op_r    <= op_r;
        rsp_clear_r <= 1'b0;
        rsp_key_r   <= key_r;
        rsp_hit_r   <= bf_done & bf_hit & ~op_r;
        rsp_err_r   <= ~bf_done;
      end else if (state_r == ST_CLEAR) begin
        rsp_valid_r <= 1'b1;
        rsp_op_r    <= op_r;
        rsp_clear_r <= 1'b1;
        rsp_key_r   <= key_r;
        rsp_hit_r   <= 1'b0;
        rsp_err_r   <= 1'b0;
      end else if ((state_r == ST_RESP) && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  // Saturating statistics; stat_clr takes priority over any increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      inserts_r  <= {CNT_W{1'b0}};
      queries_r  <= {CNT_W{1'b0}};
      hits_r     <= {CNT_W{1'b0}};
      timeouts_r <= {CNT_W{1'b0}};
    end else if (wait_exit_s) begin
      if (!bf_done) begin
        timeouts_r <= sat_inc(timeouts_r);
      end else if (op_r) begin
        inserts_r <= sat_inc(inserts_r);
      end else begin
        queries_r <= sat_inc(queries_r);
        if (bf_hit) begin
          hits_r <= sat_inc(hits_r);
        end
      end
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_op        = rsp_op_r;
  assign rsp_clear     = rsp_clear_r;
  assign rsp_key       = rsp_key_r;
  assign rsp_hit       = rsp_hit_r;
  assign rsp_err       = rsp_err_r;
  assign bf_start      = start_s;
  assign bf_clear_all  = clear_all_r;
  assign bf_op_insert  = drive_s ? op_r : 1'b0;
  assign bf_key        = drive_s ? key_r : {KEY_W{1'b0}};
  assign stat_inserts  = inserts_r;
  assign stat_queries  = queries_r;
  assign stat_hits     = hits_r;
  assign stat_timeouts = timeouts_r;

endmodule

// File: tb/tb_bloom_cmd_initiator.sv
// Scoreboard bench for bloom_cmd_initiator with an exact-set filter stand-in
// (done 3 cycles after start) and a stub mode that never answers.
module tb_bloom_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_op = 1'b0, cmd_clear = 1'b0;
  logic [31:0] cmd_key = 32'h0;
  logic        cmd_ready;
  logic        rsp_valid, rsp_op, rsp_clear, rsp_hit, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_key;
  logic        bf_start, bf_op_insert, bf_clear_all;
  logic [31:0] bf_key;
  logic        bf_busy = 1'b0, bf_done, bf_hit;
  logic        stat_clr = 1'b0;
  logic [15:0] stat_inserts, stat_queries, stat_hits, stat_timeouts;

  bloom_cmd_initiator #(.KEY_W(32), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_clear(cmd_clear), .cmd_key(cmd_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_clear(rsp_clear), .rsp_key(rsp_key),
    .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .bf_start(bf_start), .bf_op_insert(bf_op_insert), .bf_clear_all(bf_clear_all), .bf_key(bf_key),
    .bf_busy(bf_busy), .bf_done(bf_done), .bf_hit(bf_hit),
    .stat_clr(stat_clr), .stat_inserts(stat_inserts), .stat_queries(stat_queries),
    .stat_hits(stat_hits), .stat_timeouts(stat_timeouts)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int start_cnt = 0;
  int clear_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bf_start) start_cnt <= start_cnt + 1;
    if (bf_clear_all) clear_cnt <= clear_cnt + 1;
  end

  // Filter stand-in: exact membership set, done pulse 3 cycles after start.
  bit          stub = 1'b0;
  bit          mem[logic [31:0]];
  logic [2:0]  done_sr = 3'b0;
  logic        hit_q = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      done_sr <= 3'b0;
    end else begin
      done_sr <= {done_sr[1:0], bf_start & ~stub};
      if (bf_start && !stub) begin
        hit_q <= !bf_op_insert && mem.exists(bf_key);
        if (bf_op_insert) mem[bf_key] = 1'b1;
      end
      if (bf_clear_all) mem.delete();
    end
  end
  assign bf_done = done_sr[2];
  assign bf_hit  = done_sr[2] & hit_q;

  typedef struct {
    logic        op;
    logic        clr;
    logic [31:0] key;
    logic        hit;
    logic        err;
  } exp_t;
  exp_t sb_q[$];
  bit   exp_set[logic [31:0]];

  int n_cmp = 0;
  int n_err = 0;
  int acc_cyc = 0;
  int e_ins = 0, e_qry = 0, e_hit = 0, e_to = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at the negedge where cmd_valid & cmd_ready are both high.
  task automatic accept_here(input logic op, input logic clr, input logic [31:0] key);
    exp_t e;
    acc_cyc = cyc;
    e.op  = op;
    e.clr = clr;
    e.key = key;
    e.err = !clr && stub;
    e.hit = !clr && !stub && !op && exp_set.exists(key);
    if (clr) exp_set.delete();
    else if (op && !stub) exp_set[key] = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic op, input logic clr, input logic [31:0] key);
    int g;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_clear = clr; cmd_key = key;
    g = 0;
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    check_val("cmd_accept", cmd_ready, 1);
    accept_here(op, clr, key);
  endtask

  task automatic recv_rsp(input int exp_lat, input int hold, input bit upd);
    exp_t e;
    int g;
    g = 0;
    while (!rsp_valid && g < 40) begin @(negedge clk); g++; end
    check_val("rsp_valid_seen", rsp_valid, 1);
    check_val("latency", cyc - acc_cyc, exp_lat);
    check_val("sb_nonempty", sb_q.size() != 0, 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check_val("hold_valid", rsp_valid, 1);
      check_val("hold_key", rsp_key, e.key);
      check_val("hold_hit", rsp_hit, e.hit);
      check_val("hold_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    check_val("rsp_op", rsp_op, e.op);
    check_val("rsp_clear", rsp_clear, e.clr);
    check_val("rsp_key", rsp_key, e.key);
    check_val("rsp_hit", rsp_hit, e.hit);
    check_val("rsp_err", rsp_err, e.err);
    if (upd && !e.clr) begin
      if (e.err) e_to++;
      else if (e.op) e_ins++;
      else begin e_qry++; if (e.hit) e_hit++; end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val("rsp_valid_drop", rsp_valid, 0);
    check_val("cmd_ready_back", cmd_ready, 1);
    check_val("stat_inserts", stat_inserts, e_ins);
    check_val("stat_queries", stat_queries, e_qry);
    check_val("stat_hits", stat_hits, e_hit);
    check_val("stat_timeouts", stat_timeouts, e_to);
  endtask

  initial begin
    int s0;
    repeat (3) @(negedge clk);
    check_val("rst_cmd_ready", cmd_ready, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_bf_start", bf_start, 0);
    check_val("rst_bf_clear_all", bf_clear_all, 0);
    check_val("rst_stats", {stat_inserts, stat_queries, stat_hits, stat_timeouts}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("cmd_ready_after_rst", cmd_ready, 1);

    // Insert then query the same key.
    send_cmd(1'b1, 1'b0, 32'hDEADBEEF);
    check_val("bf_key_issue", bf_key, 32'hDEADBEEF);
    check_val("bf_op_insert_issue", bf_op_insert, 1);
    recv_rsp(5, 0, 1'b1);
    send_cmd(1'b0, 1'b0, 32'hDEADBEEF);
    recv_rsp(5, 0, 1'b1);

    // Miss on a key never inserted; exactly one start pulse.
    s0 = start_cnt;
    send_cmd(1'b0, 1'b0, 32'h12345678);
    recv_rsp(5, 0, 1'b1);
    check_val("one_start_pulse", start_cnt - s0, 1);

    // CLEAR wipes the filter and leaves counters alone.
    s0 = clear_cnt;
    send_cmd(1'b0, 1'b1, 32'h0000AAAA);
    recv_rsp(2, 0, 1'b1);
    check_val("one_clear_pulse", clear_cnt - s0, 1);
    send_cmd(1'b0, 1'b0, 32'hDEADBEEF);
    recv_rsp(5, 0, 1'b1);

    // Filter never answers: timeout 8 cycles after entering WAIT.
    stub = 1'b1;
    send_cmd(1'b0, 1'b0, 32'h55AA55AA);
    recv_rsp(10, 0, 1'b1);
    stub = 1'b0;
    send_cmd(1'b1, 1'b0, 32'hCAFE0001);
    recv_rsp(5, 0, 1'b1);

    // Backpressure with a command already waiting.
    send_cmd(1'b0, 1'b0, 32'hCAFE0001);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_clear = 1'b0; cmd_key = 32'h0BADF00D;
    recv_rsp(5, 10, 1'b1);
    accept_here(1'b1, 1'b0, 32'h0BADF00D);
    recv_rsp(5, 0, 1'b1);

    // Filter busy for 6 ISSUE cycles.
    bf_busy = 1'b1;
    s0 = start_cnt;
    send_cmd(1'b0, 1'b0, 32'h0BADF00D);
    while (cyc < acc_cyc + 7) begin
      check_val("no_start_while_busy", bf_start, 0);
      @(negedge clk);
    end
    bf_busy = 1'b0;
    recv_rsp(11, 0, 1'b1);
    check_val("busy_one_start", start_cnt - s0, 1);

    // stat_clr on the cycle the query completes.
    send_cmd(1'b0, 1'b0, 32'hCAFE0001);
    while (cyc < acc_cyc + 4) @(negedge clk);
    check_val("done_coincident", bf_done, 1);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    e_ins = 0; e_qry = 0; e_hit = 0; e_to = 0;
    recv_rsp(5, 0, 1'b0);

    // Reset in WAIT abandons the command.
    stub = 1'b1;
    send_cmd(1'b0, 1'b0, 32'h77778888);
    while (cyc < acc_cyc + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    void'(sb_q.pop_front());
    check_val("mid_rst_cmd_ready", cmd_ready, 0);
    check_val("mid_rst_rsp_valid", rsp_valid, 0);
    check_val("mid_rst_bf_start", bf_start, 0);
    check_val("mid_rst_bf_key", bf_key, 0);
    check_val("mid_rst_bf_op_insert", bf_op_insert, 0);
    check_val("mid_rst_rsp_key", rsp_key, 0);
    rst = 1'b0;
    stub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("no_rsp_after_rst", rsp_valid, 0);
    end
    check_val("idle_after_rst", cmd_ready, 1);
    send_cmd(1'b0, 1'b0, 32'hCAFE0001);
    recv_rsp(5, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
